// File: rtl/dma_priority_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : dma_priority_arbiter
// Description : Folds hardware DREQ lines and software requests into a single
//               service request. Holds a one-hot DACK lock for each service cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module dma_priority_arbiter #(
    parameter  int NUM_CH   = 4,
    parameter  int ROT_INIT = 0,
    localparam int PTR_W    = $clog2(NUM_CH)
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [NUM_CH-1:0] DREQ,
    input  logic              dreqSenseLow,
    input  logic              dackSenseHigh,
    input  logic              rotatingPri,
    input  logic [NUM_CH-1:0] maskBits,
    input  logic              swReqWrite,
    input  logic [PTR_W:0]    swReqData,
    input  logic              assertDACK,
    input  logic              intEOP,
    output logic              dmaRequest,
    output logic [NUM_CH-1:0] DACK,
    output logic [PTR_W-1:0]  grantCh,
    output logic              grantValid
);

    localparam logic [0:0]       S_IDLE   = 1'b0;
    localparam logic [0:0]       S_GRANT  = 1'b1;
    localparam logic [PTR_W:0]   c_NUM_CH = (PTR_W+1)'(NUM_CH);
    localparam logic [PTR_W-1:0] c_LAST   = PTR_W'(NUM_CH - 1);

    logic [0:0]        r_state;
    logic [NUM_CH-1:0] r_snapshot;
    logic [NUM_CH-1:0] r_sw_req;
    logic [NUM_CH-1:0] r_onehot;
    logic [PTR_W-1:0]  r_pointer;
    logic              r_rot_q;

    logic [NUM_CH-1:0] w_eff_req;
    logic [NUM_CH-1:0] w_sw_req_next;
    logic [NUM_CH-1:0] w_onehot_next;
    logic [PTR_W-1:0]  w_winner;
    logic              w_found;
    logic [PTR_W-1:0]  w_ptr_next;

    // Software requests bypass the mask; hardware requests are sense-corrected first.
    assign w_eff_req  = ((DREQ ^ {NUM_CH{dreqSenseLow}}) & ~maskBits) | r_sw_req;
    assign w_ptr_next = (grantCh == c_LAST) ? '0 : grantCh + PTR_W'(1);

    // Circular scan of the snapshot starting at the pointer (ch0 when fixed).
    always_comb begin
        logic [PTR_W:0] idx;
        logic [PTR_W:0] base;
        w_found  = 1'b0;
        w_winner = '0;
        idx      = '0;
        base     = rotatingPri ? {1'b0, r_pointer} : '0;
        for (int k = 0; k < NUM_CH; k++) begin
            idx = base + (PTR_W+1)'(k);
            if (idx >= c_NUM_CH) begin
                idx = idx - c_NUM_CH;
            end
            if (!w_found && r_snapshot[idx[PTR_W-1:0]]) begin
                w_found  = 1'b1;
                w_winner = idx[PTR_W-1:0];
            end
        end
    end

    // A write to the same channel as a terminal-count clear takes precedence.
    always_comb begin
        w_sw_req_next = r_sw_req;
        if (intEOP && grantValid) begin
            w_sw_req_next[grantCh] = 1'b0;
        end
        if (swReqWrite) begin
            w_sw_req_next[swReqData[PTR_W-1:0]] = swReqData[PTR_W];
        end
    end

    always_comb begin
        w_onehot_next = '0;
        if (r_state == S_IDLE) begin
            if (assertDACK && w_found) begin
                w_onehot_next = NUM_CH'(1) << w_winner;
            end
        end else if (assertDACK) begin
            w_onehot_next = r_onehot;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state    <= S_IDLE;
            r_snapshot <= '0;
            r_sw_req   <= '0;
            r_onehot   <= '0;
            r_pointer  <= PTR_W'(ROT_INIT);
            r_rot_q    <= rotatingPri;
            dmaRequest <= 1'b0;
            grantCh    <= '0;
            grantValid <= 1'b0;
            DACK       <= dackSenseHigh ? '0 : '1;
        end else begin
            r_rot_q    <= rotatingPri;
            r_sw_req   <= w_sw_req_next;
            r_onehot   <= w_onehot_next;
            dmaRequest <= grantValid ? 1'b0 : |w_eff_req;
            DACK       <= dackSenseHigh ? w_onehot_next : ~w_onehot_next;
            case (r_state)
                S_IDLE: begin
                    r_snapshot <= w_eff_req;
                    if (assertDACK && w_found) begin
                        r_state    <= S_GRANT;
                        grantCh    <= w_winner;
                        grantValid <= 1'b1;
                    end
                end
                S_GRANT: begin
                    if (!assertDACK) begin
                        r_state    <= S_IDLE;
                        grantValid <= 1'b0;
                        if (rotatingPri) begin
                            r_pointer <= w_ptr_next;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
            // Leaving rotating mode restarts priority at ch0.
            if (r_rot_q && !rotatingPri) begin
                r_pointer <= '0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dma_priority_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_dma_priority_arbiter
// Description : Directed self-checking bench for dma_priority_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dma_priority_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] dreq;
    logic       dreq_sense_low;
    logic       dack_sense_high;
    logic       rotating_pri;
    logic [3:0] mask_bits;
    logic       sw_req_write;
    logic [2:0] sw_req_data;
    logic       assert_dack;
    logic       int_eop;
    logic       dma_request;
    logic [3:0] dack;
    logic [1:0] grant_ch;
    logic       grant_valid;

    int n_checks = 0;
    int n_pass   = 0;

    dma_priority_arbiter #(.NUM_CH(4), .ROT_INIT(0)) dut (
        .CLK           (clk),
        .RESET         (rst),
        .DREQ          (dreq),
        .dreqSenseLow  (dreq_sense_low),
        .dackSenseHigh (dack_sense_high),
        .rotatingPri   (rotating_pri),
        .maskBits      (mask_bits),
        .swReqWrite    (sw_req_write),
        .swReqData     (sw_req_data),
        .assertDACK    (assert_dack),
        .intEOP        (int_eop),
        .dmaRequest    (dma_request),
        .DACK          (dack),
        .grantCh       (grant_ch),
        .grantValid    (grant_valid)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    initial begin
        rst = 1'b1; dreq = '0; dreq_sense_low = 1'b0; dack_sense_high = 1'b0;
        rotating_pri = 1'b0; mask_bits = '0; sw_req_write = 1'b0; sw_req_data = '0;
        assert_dack = 1'b0; int_eop = 1'b0;

        // Reset with active-low DACK
        tick();
        chk("rst_dack", 32'(dack), 32'hF);
        chk("rst_gv", 32'(grant_valid), 0);
        chk("rst_dreq", 32'(dma_request), 0);
        chk("rst_gch", 32'(grant_ch), 0);
        rst = 1'b0; dack_sense_high = 1'b1;
        tick();
        chk("idle_dack_hi", 32'(dack), 32'h0);

        // Fixed priority, DREQ=1010
        dreq = 4'b1010;
        tick();
        chk("fix_dmareq", 32'(dma_request), 1);
        assert_dack = 1'b1;
        tick();
        chk("fix_dack", 32'(dack), 32'h2);
        chk("fix_gch", 32'(grant_ch), 1);
        chk("fix_gv", 32'(grant_valid), 1);
        dreq = 4'b0001;
        tick();
        chk("fix_hold_dack", 32'(dack), 32'h2);
        chk("fix_hold_dmareq", 32'(dma_request), 0);
        assert_dack = 1'b0;
        tick();
        chk("fix_rel_gv", 32'(grant_valid), 0);
        chk("fix_rel_dack", 32'(dack), 32'h0);
        dreq = '0;
        tick(); tick();

        // Rotating priority, all channels requesting
        rotating_pri = 1'b1; dreq = 4'b1111;
        tick();
        for (int k = 0; k < 5; k++) begin
            assert_dack = 1'b1;
            tick();
            chk($sformatf("rot_gch%0d", k), 32'(grant_ch), k % 4);
            chk($sformatf("rot_dack%0d", k), 32'(dack), 32'(1 << (k % 4)));
            assert_dack = 1'b0;
            tick();
            chk($sformatf("rot_rel%0d", k), 32'(grant_valid), 0);
        end
        rotating_pri = 1'b0; dreq = '0;
        tick(); tick();

        // Masked hardware request served via software request
        mask_bits = 4'b0100; dreq = 4'b0100;
        sw_req_write = 1'b1; sw_req_data = 3'b110;
        tick();
        chk("sw_masked_dmareq", 32'(dma_request), 0);
        sw_req_write = 1'b0;
        tick();
        chk("sw_dmareq", 32'(dma_request), 1);
        assert_dack = 1'b1;
        tick();
        chk("sw_gch", 32'(grant_ch), 2);
        chk("sw_dack", 32'(dack), 32'h4);
        tick();
        assert_dack = 1'b0; int_eop = 1'b1;
        tick();
        int_eop = 1'b0;
        tick();
        chk("eop_dmareq", 32'(dma_request), 0);
        chk("eop_gv", 32'(grant_valid), 0);

        // Empty snapshot: no spurious acknowledge
        assert_dack = 1'b1;
        tick();
        chk("empty_dack", 32'(dack), 32'h0);
        chk("empty_gv", 32'(grant_valid), 0);
        assert_dack = 1'b0;
        tick();

        // Write wins over EOP on same channel; DACK re-polarised mid-grant
        mask_bits = 4'b1111; dreq = '0;
        sw_req_write = 1'b1; sw_req_data = 3'b101;
        tick();
        sw_req_write = 1'b0;
        tick();
        chk("we_dmareq", 32'(dma_request), 1);
        assert_dack = 1'b1;
        tick();
        chk("we_gch", 32'(grant_ch), 1);
        dack_sense_high = 1'b0;
        tick();
        chk("pol_dack", 32'(dack), 32'hD);
        chk("pol_gv", 32'(grant_valid), 1);
        dack_sense_high = 1'b1; assert_dack = 1'b0; int_eop = 1'b1;
        sw_req_write = 1'b1; sw_req_data = 3'b101;
        tick();
        int_eop = 1'b0; sw_req_write = 1'b0;
        tick();
        chk("we_keep_dmareq", 32'(dma_request), 1);
        sw_req_write = 1'b1; sw_req_data = 3'b001;
        tick();
        sw_req_write = 1'b0;
        tick();
        chk("we_clr_dmareq", 32'(dma_request), 0);

        // Reset during a grant on ch3 after pointer has moved to 2
        mask_bits = '0; rotating_pri = 1'b1; dreq = 4'b0010;
        tick();
        assert_dack = 1'b1;
        tick();
        chk("pre_gch1", 32'(grant_ch), 1);
        assert_dack = 1'b0; dreq = '0;
        tick();
        sw_req_write = 1'b1; sw_req_data = 3'b111;
        tick();
        sw_req_write = 1'b0;
        tick();
        assert_dack = 1'b1;
        tick();
        chk("pre_gch3", 32'(grant_ch), 3);
        rst = 1'b1;
        tick();
        chk("mid_rst_dack", 32'(dack), 32'h0);
        chk("mid_rst_gv", 32'(grant_valid), 0);
        chk("mid_rst_dmareq", 32'(dma_request), 0);
        rst = 1'b0; assert_dack = 1'b0;
        tick(); tick();
        chk("post_rst_swreq", 32'(dma_request), 0);
        dreq = 4'b1111;
        tick();
        assert_dack = 1'b1;
        tick();
        chk("post_rst_ptr", 32'(grant_ch), 0);
        assert_dack = 1'b0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
